mul_unit: RTL and testbench

//  RV32M multiply execution unit: sits between the EX-stage operand/decode path and the

---
 rtl/mul_unit_pkg.sv | 24 ++
 rtl/mul_unit_wallace.sv | 49 ++++
 rtl/mul_unit.sv | 115 +++++++++++
 tb/tb_mul_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_unit_pkg.sv
// Shared types for the RV32M multiply unit: operation encoding, FSM states and the
// operand magnitude helper used when converting signed operands for the unsigned tree.
package mul_types;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mul_state_t;

    // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
    function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/mul_unit_wallace.sv
// Combinational 32x32 unsigned multiplier: partial products reduced by 3:2 carry-save
// levels (32->22->15->10->7->5->4->3->2 rows) followed by one carry-propagate add.
module wallace (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] prod_o
);

    function automatic logic [63:0] tree_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] rows [32];
        logic [63:0] nxt  [32];
        logic [63:0] x, y, z;
        int          n;
        int          m;
        for (int i = 0; i < 32; i++) begin
            rows[i] = b[i] ? (64'(a) << i) : 64'd0;
        end
        n = 32;
        for (int lvl = 0; lvl < 8; lvl++) begin
            nxt = '{default: 64'd0};
            m   = 0;
            for (int g = 0; g < 11; g++) begin
                if (3 * g + 2 < n) begin
                    x = rows[5'(3 * g)];
                    y = rows[5'(3 * g + 1)];
                    z = rows[5'(3 * g + 2)];
                    nxt[5'(m)]     = x ^ y ^ z;
                    nxt[5'(m + 1)] = ((x & y) | (x & z) | (y & z)) << 1;
                    m = m + 2;
                end
            end
            // Rows that did not fill a complete group of three pass straight through.
            for (int j = 0; j < 32; j++) begin
                if (j >= 3 * (n / 3) && j < n) begin
                    nxt[5'(m)] = rows[5'(j)];
                    m = m + 1;
                end
            end
            rows = nxt;
            n    = m;
        end
        return rows[0] + rows[1];
    endfunction

    always_comb begin
        prod_o = tree_mul(a_i, b_i);
    end

endmodule

// File: rtl/mul_unit.sv
// RV32M multiply execution unit: latches operand magnitudes, lets the wallace tree settle
// for MUL_CYCLES cycles, sign-corrects the product and returns the selected word.
module mul_unit
    import mul_types::*;
#(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        busy
);

    localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

    mul_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_mag_q, b_mag_q;
    mul_op_t     op_q;
    logic        neg_q;
    logic [63:0] prod_q;
    logic [31:0] resp_data_q;

    mul_op_t     op_in;
    logic        a_signed, b_signed;
    logic        accept;
    logic [63:0] tree_prod;
    logic [63:0] fixed_prod;

    assign op_in    = mul_op_t'(req_op);
    assign a_signed = (op_in == MULH) || (op_in == MULHSU);
    assign b_signed = (op_in == MULH);
    assign accept   = (state_q == IDLE) && req_valid && !flush;

    // Operand regs to prod_q is a MUL_CYCLES multicycle path; the counter guarantees
    // the tree inputs are stable for that long before prod_q samples.
    wallace u_wallace (
        .a_i    (a_mag_q),
        .b_i    (b_mag_q),
        .prod_o (tree_prod)
    );

    assign fixed_prod = neg_q ? (~prod_q + 64'd1) : prod_q;

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                    cnt_d   = CNT_INIT;
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            FIX:  state_d = flush ? IDLE : DONE;
            DONE: begin
                if (resp_ready || flush) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all regs update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            a_mag_q     <= 32'd0;
            b_mag_q     <= 32'd0;
            op_q        <= MUL;
            neg_q       <= 1'b0;
            prod_q      <= 64'd0;
            resp_data_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                a_mag_q <= magnitude(req_a, a_signed);
                b_mag_q <= magnitude(req_b, b_signed);
                op_q    <= op_in;
                neg_q   <= (a_signed & req_a[31]) ^ (b_signed & req_b[31]);
            end
            if (state_q == CALC && cnt_q == 4'd0 && !flush) begin
                prod_q <= tree_prod;
            end
            if (state_q == FIX && !flush) begin
                resp_data_q <= (op_q == MUL) ? fixed_prod[31:0] : fixed_prod[63:32];
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner cases, handshake, flush and reset
// scenarios, then randomized operations checked against a wide-arithmetic reference.
module tb_mul_unit;

    localparam int MC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mul_unit #(.MUL_CYCLES(MC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: extend each operand to 64 bits by its signedness; the low 64 bits of the
    // product are exact for every RV32M variant.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ax, bx, p;
        ax = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        bx = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ax * bx;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait for the response, stall it for `hold` cycles, then take it.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int          lat;
        logic [31:0] exp;
        exp        = ref_mul(op, a, b);
        req_op     = op;
        req_a      = a;
        req_b      = b;
        req_valid  = 1'b1;
        resp_ready = 1'b0;
        check({tag, "/req_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_op    = 2'($urandom);
        lat = 1;
        while (!resp_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(MC + 2));
        check({tag, "/data"}, resp_data, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "/stall_valid"}, 32'(resp_valid), 32'd1);
            check({tag, "/stall_data"}, resp_data, exp);
            check({tag, "/stall_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, "/idle_ready"}, 32'(req_ready), 32'd1);
        check({tag, "/idle_valid"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int          seen;
        logic [31:0] corners [5];
        logic [31:0] ra, rb;
        logic [1:0]  rop;

        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'h8000_0000;
        corners[3] = 32'hFFFF_FFFF;
        corners[4] = 32'h7FFF_FFFF;

        repeat (2) tick();
        check("reset/req_ready", 32'(req_ready), 32'd1);
        check("reset/resp_valid", 32'(resp_valid), 32'd0);
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/resp_data", resp_data, 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 0);
        check("mul_7x6/const", resp_data, 32'h0000_002A);
        run_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 0);
        check("mulh_min/const", resp_data, 32'h4000_0000);
        run_op("mul_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 0);
        check("mul_min/const", resp_data, 32'h0000_0000);
        run_op("mulhsu_ff", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mulhsu_ff/const", resp_data, 32'hFFFF_FFFF);
        run_op("mulh_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 0);
        check("mulh_m3x5/const", resp_data, 32'hFFFF_FFFF);
        run_op("mul_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 0);
        check("mul_m3x5/const", resp_data, 32'hFFFF_FFF1);
        run_op("mulhu_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mulhu_ff/const", resp_data, 32'hFFFF_FFFE);
        run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mul_ff/const", resp_data, 32'h0000_0001);
        run_op("mulh_zero_neg", 2'b01, 32'h0000_0000, 32'hFFFF_FFFF, 0);

        run_op("backpressure", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5);
        run_op("back_to_back", 2'b10, 32'hDEAD_BEEF, 32'h0000_1000, 0);

        // Flush during CALC: the op is dropped and no response ever appears.
        req_op = 2'b00; req_a = 32'd3; req_b = 32'd9; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("flush_calc/busy", 32'(busy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_calc/req_ready", 32'(req_ready), 32'd1);
        check("flush_calc/busy_after", 32'(busy), 32'd0);
        seen = 0;
        repeat (10) begin
            tick();
            if (resp_valid) seen++;
        end
        check("flush_calc/no_resp", 32'(seen), 32'd0);

        // Flush alongside a request in IDLE: the request is refused.
        req_valid = 1'b1; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        check("flush_idle/busy", 32'(busy), 32'd0);
        check("flush_idle/req_ready", 32'(req_ready), 32'd1);

        // Flush in DONE with resp_ready: the handshake completes normally.
        req_op = 2'b00; req_a = 32'd7; req_b = 32'd6; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        seen = 1;
        while (!resp_valid && seen < 40) begin
            tick();
            seen++;
        end
        check("flush_done/latency", 32'(seen), 32'(MC + 2));
        check("flush_done/data", resp_data, 32'h0000_002A);
        flush = 1'b1; resp_ready = 1'b1;
        tick();
        flush = 1'b0; resp_ready = 1'b0;
        check("flush_done/idle", 32'(req_ready), 32'd1);
        check("flush_done/valid", 32'(resp_valid), 32'd0);

        // Asynchronous reset while in FIX: outputs clear before any clock edge.
        req_op = 2'b11; req_a = 32'hFFFF_0000; req_b = 32'h0001_0000; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("rst_fix/busy_before", 32'(busy), 32'd1);
        check("rst_fix/data_before", resp_data, 32'h0000_002A);
        rst_n = 1'b0;
        #1;
        check("rst_fix/resp_valid", 32'(resp_valid), 32'd0);
        check("rst_fix/busy", 32'(busy), 32'd0);
        check("rst_fix/resp_data", resp_data, 32'd0);
        check("rst_fix/req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            tick();
            if (resp_valid) seen++;
        end
        check("rst_fix/no_resp", 32'(seen), 32'd0);

        for (int k = 0; k < 40; k++) begin
            rop = 2'($urandom);
            ra  = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
            rb  = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
            run_op($sformatf("rand%0d", k), rop, ra, rb, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
